debounce_scheduler: RTL
=======================

Name: debounce_scheduler

Overview:
Round-robin sampling controller that shares one debounce evaluation slot across NUM_CH button inputs, so the mixer does not need one free-running debounce counter per button. A prescaler paces the sample slots. Each slot shifts one channel's synchronised input into that channel's history register, then evaluates it. The block drives debounced levels plus single-cycle rise/fall pulses to the RGB mixer's channel select and increment logic.

Parameters:
NUM_CH, 3, number of button channels (>=2)
HIST_WIDTH, 8, samples per channel history; all must agree to change state (>=2)
PRESCALE, 16, clocks spent in WAIT per slot (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  run scheduler; low parks it in IDLE after the current slot
buttons  input  NUM_CH  raw asynchronous button levels
debounced  output  NUM_CH  registered debounced levels
rise  output  NUM_CH  one-cycle pulse when debounced[i] goes 0->1
fall  output  NUM_CH  one-cycle pulse when debounced[i] goes 1->0
slot_idx  output  $clog2(NUM_CH)  channel currently owning the slot
busy  output  1  high in any state except IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. No asynchronous logic except the input synchroniser.
- Reset clears: debounced=0, rise=0, fall=0, slot_idx=0, busy=0, all histories=0, prescaler=0, sync flops=0, state=IDLE.
- Input path: 2-flop synchroniser per bit. Only sync[i] is ever sampled.
- FSM states: IDLE, WAIT, SAMPLE, EVAL, ADVANCE.
- IDLE: prescaler held at 0. If enable=1, go to WAIT next cycle.
- WAIT: prescaler counts 0..PRESCALE-1. At PRESCALE-1, clear the prescaler and go to SAMPLE. WAIT lasts exactly PRESCALE cycles.
- SAMPLE: hist[slot_idx] <= {hist[slot_idx][HIST_WIDTH-2:0], sync[slot_idx]}. Go to EVAL.
- EVAL: only channel slot_idx is evaluated.
  - hist all ones and debounced=0: set debounced=1 and pulse rise for 1 cycle.
  - hist all zeros and debounced=1: set debounced=0 and pulse fall for 1 cycle.
  - Otherwise hold (hysteresis).
  - Go to ADVANCE.
- ADVANCE: slot_idx wraps from NUM_CH-1 to 0, otherwise increments. Go to WAIT if enable=1, else IDLE.
- Slot period = PRESCALE+3 cycles. Round period = NUM_CH*(PRESCALE+3).
- rise/fall are asserted for exactly the one cycle after EVAL. At most one channel's bit is high at any time; rise and fall are never high together.
- enable deassert mid-slot: the current slot completes through ADVANCE, then IDLE. Histories, debounced and slot_idx are retained. Re-enable resumes at the retained slot_idx.
- reset mid-slot: immediate return to reset values. No rise/fall pulse is produced on the reset cycle or the following cycle.
- Histories of non-selected channels never change.
- The debounced state is held until the opposite unanimous history is seen. Mixed histories never toggle the output.

Test Plan:
(All with NUM_CH=3, HIST_WIDTH=4, PRESCALE=4: slot=7, round=21 cycles.)
- Reset, then enable=1 with buttons=000 -> busy=1 after 1 cycle; slot_idx sequences 0,1,2,0 with 7-cycle spacing; debounced stays 000; no pulses.
- buttons[0] held 1 from cycle 0 -> debounced[0] rises no earlier than cycle 63 and no later than cycle 93. rise[0] is high exactly 1 cycle; other bits stay 0.
- buttons[1] glitches high for 10 cycles, then returns low -> at most 1 sample is 1; debounced[1] stays 0; no rise.
- Channel 2 debounced high, then buttons[2] low for 4+ rounds -> fall[2] is a single 1-cycle pulse and debounced[2]=0. An alternating 1/0 input per round causes no change.
- enable dropped 2 cycles into WAIT for slot_idx=1 -> that slot completes; state goes IDLE, busy=0, slot_idx=2. Re-enable: first SAMPLE targets channel 2.
- reset asserted during EVAL with a pending rise -> next cycle all outputs are 0, rise never pulses, and histories are cleared.

Source files
------------

// File: rtl/debounce_scheduler.sv
// Purpose: time-shared debouncer; one evaluation slot walks round-robin over NUM_CH synchronised buttons.
// Latency: a button change reaches debounced after HIST_WIDTH rounds of NUM_CH*(PRESCALE+3) clocks plus sync delay.
// Backpressure: none; enable low parks the scheduler in IDLE after the slot in flight completes.
module debounce_scheduler #(
   parameter int NUM_CH     = 3,
   parameter int HIST_WIDTH = 8,
   parameter int PRESCALE   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_CH-1:0]         buttons,
   output logic [NUM_CH-1:0]         debounced,
   output logic [NUM_CH-1:0]         rise,
   output logic [NUM_CH-1:0]         fall,
   output logic [$clog2(NUM_CH)-1:0] slot_idx,
   output logic                      busy
);

   localparam int SLOT_W = $clog2(NUM_CH);
   localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [PS_W-1:0]       PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(NUM_CH - 1);
   localparam logic [HIST_WIDTH-1:0] HIST_ONES = {HIST_WIDTH{1'b1}};
   localparam logic [HIST_WIDTH-1:0] HIST_ZERO = '0;

   // One slot = PRESCALE clocks of WAIT, then SAMPLE, EVAL and ADVANCE.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SAMPLE,
      ST_EVAL,
      ST_ADVANCE
   } state_t;

   state_t                  state_q,  state_d;
   logic [PS_W-1:0]         ps_q,     ps_d;
   logic [SLOT_W-1:0]       slot_q,   slot_d;
   logic [NUM_CH-1:0]       sync1_q;
   logic [NUM_CH-1:0]       sync2_q;
   logic [HIST_WIDTH-1:0]   hist_q [NUM_CH];
   logic [HIST_WIDTH-1:0]   hist_d [NUM_CH];
   logic [NUM_CH-1:0]       deb_q,    deb_d;
   logic [NUM_CH-1:0]       rise_q,   rise_d;
   logic [NUM_CH-1:0]       fall_q,   fall_d;

   // History and synchronised level of the channel that owns the slot.
   logic [HIST_WIDTH-1:0]   sel_hist;
   logic                    sel_sync;
   logic                    sel_deb;

   assign sel_hist = hist_q[slot_q];
   assign sel_sync = sync2_q[slot_q];
   assign sel_deb  = deb_q[slot_q];

   // Two-flop synchroniser; only the second stage feeds the histories.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= buttons;
         sync2_q <= sync1_q;
      end
   end

   // Scheduler state, prescaler and slot owner registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ps_q    <= '0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         slot_q  <= slot_d;
      end
   end

   // Next-state logic: pace slots with the prescaler and rotate the owner.
   always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      slot_d  = slot_q;
      unique case (state_q)
         ST_IDLE: begin
            ps_d = '0;
            if (enable) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ps_q == PS_LAST) begin
               ps_d    = '0;
               state_d = ST_SAMPLE;
            end else begin
               ps_d = ps_q + PS_W'(1);
            end
         end
         ST_SAMPLE: begin
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            state_d = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            // enable is looked at only here, so a slot always runs to completion.
            state_d = enable ? ST_WAIT : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            ps_d    = '0;
         end
      endcase
   end

   // Datapath next-state: shift one history in SAMPLE, judge it in EVAL.
   always_comb begin
      hist_d = hist_q;
      deb_d  = deb_q;
      rise_d = '0;
      fall_d = '0;
      if (state_q == ST_SAMPLE) begin
         hist_d[slot_q] = {sel_hist[HIST_WIDTH-2:0], sel_sync};
      end
      if (state_q == ST_EVAL) begin
         // Only a unanimous history flips the level; anything mixed holds it.
         if ((sel_hist == HIST_ONES) && !sel_deb) begin
            deb_d[slot_q]  = 1'b1;
            rise_d[slot_q] = 1'b1;
         end else if ((sel_hist == HIST_ZERO) && sel_deb) begin
            deb_d[slot_q]  = 1'b0;
            fall_d[slot_q] = 1'b1;
         end
      end
   end

   // Histories, debounced levels and edge pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            hist_q[i] <= '0;
         end
         deb_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            hist_q[i] <= hist_d[i];
         end
         deb_q  <= deb_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign debounced = deb_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign slot_idx  = slot_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
